maze_job_sched: RTL and testbench

//  Shares one serial maze solver (15x15 maze, BFS path search) between N_REQ requesters.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/maze_job_sched_rr_arbiter.sv | 45 ++++
 rtl/maze_job_sched.sv | 197 +++++++++++++++++++
 tb/tb_maze_job_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
//   Shared types and constants for the maze job scheduler and its arbiter.
//   No ports. Exports MAZE_DIM/MAZE_BITS, coord_t, sched_state_e and
//   rr_wrap(), the modulo-n increment used for round-robin pointers.
// -----------------------------------------------------------------------------
package maze_pkg;

  localparam int MAZE_DIM  = 15;
  localparam int MAZE_BITS = MAZE_DIM * MAZE_DIM;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } sched_state_e;

  // Next index in a ring of n entries: idx+1, wrapping to 0.
  function automatic int rr_wrap(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/maze_job_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first set request at or after the
//   pointer, wrapping modulo N_REQ.
//   Ports:
//     i_req   [N_REQ-1:0]  request vector
//     i_ptr   [PW-1:0]     index with the highest priority this round
//     o_grant [N_REQ-1:0]  one-hot winner (all zero when no request)
//     o_idx   [PW-1:0]     binary winner index (0 when no request)
//     o_any                at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import maze_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  logic [PW-1:0] w_scan;

  // Walk the ring once starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_scan  = i_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[w_scan]) begin
        o_any           = 1'b1;
        o_idx           = w_scan;
        o_grant[w_scan] = 1'b1;
      end else begin
        o_any = o_any;
      end
      w_scan = PW'(rr_wrap(int'(w_scan), N_REQ));
    end
  end

endmodule

// File: rtl/maze_job_sched.sv
// -----------------------------------------------------------------------------
// maze_job_sched
//   Shares one serial BFS maze solver between N_REQ requesters. A round-robin
//   winner streams its MAZE_BITS maze bits to the solver; the solver's path or
//   "no path" verdict is returned to that winner only. A silent solver is
//   aborted after TIMEOUT cycles, and GAP_CYC idle cycles follow every job.
//   Ports:
//     clk, rst_n                 clock / async active-low reset
//     req, req_bit   [N_REQ]     requests (held until grant) and maze bits
//     grant          [N_REQ]     one-hot, high MAZE_BITS cycles for the winner
//     ms_maze, ms_in_valid       maze stream to the solver (1 cycle behind grant)
//     ms_out_valid, ms_maze_not_valid, ms_out_x/y   solver results
//     rsp_valid      [N_REQ]     one-hot response strobe to the winner
//     rsp_not_valid, rsp_x/y     response payload ("no path" / path point)
//     busy                       any state other than IDLE
//     timeout_err                1-cycle pulse when a job is aborted
// -----------------------------------------------------------------------------
module maze_job_sched #(
  parameter int N_REQ     = 2,
  parameter int MAZE_BITS = 225,
  parameter int TIMEOUT   = 1023,
  parameter int GAP_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_bit,
  output logic [N_REQ-1:0]     grant,
  output logic                 ms_maze,
  output logic                 ms_in_valid,
  input  logic                 ms_out_valid,
  input  logic                 ms_maze_not_valid,
  input  maze_pkg::coord_t     ms_out_x,
  input  maze_pkg::coord_t     ms_out_y,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_not_valid,
  output maze_pkg::coord_t     rsp_x,
  output maze_pkg::coord_t     rsp_y,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PW  = $clog2(N_REQ);
  localparam int BCW = $clog2(MAZE_BITS);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  maze_pkg::sched_state_e r_state;
  logic [PW-1:0]          r_ptr;
  logic [PW-1:0]          r_win;
  logic [N_REQ-1:0]       r_grant;
  logic [BCW-1:0]         r_bit_cnt;
  logic [TW-1:0]          r_timer;
  logic [GW-1:0]          r_gap_cnt;
  logic                   r_ms_maze;
  logic                   r_ms_in_valid;
  logic [N_REQ-1:0]       r_rsp_valid;
  logic                   r_rsp_not_valid;
  maze_pkg::coord_t       r_rsp_x;
  maze_pkg::coord_t       r_rsp_y;
  logic                   r_timeout_err;

  logic [N_REQ-1:0]       w_arb_grant;
  logic [PW-1:0]          w_arb_idx;
  logic                   w_arb_any;
  logic [N_REQ-1:0]       w_win_oh;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Response strobes go to the latched winner only (grant is already low then).
  assign w_win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;

  // Scheduler FSM with its counters and registered solver/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= maze_pkg::IDLE;
      r_ptr           <= '0;
      r_win           <= '0;
      r_grant         <= '0;
      r_bit_cnt       <= '0;
      r_timer         <= '0;
      r_gap_cnt       <= '0;
      r_ms_maze       <= 1'b0;
      r_ms_in_valid   <= 1'b0;
      r_rsp_valid     <= '0;
      r_rsp_not_valid <= 1'b0;
      r_rsp_x         <= 4'd0;
      r_rsp_y         <= 4'd0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        maze_pkg::IDLE: begin
          r_ms_in_valid   <= 1'b0;
          r_rsp_valid     <= '0;
          r_rsp_not_valid <= 1'b0;
          if (w_arb_any) begin
            r_win     <= w_arb_idx;
            r_grant   <= w_arb_grant;
            r_ptr     <= PW'(maze_pkg::rr_wrap(int'(w_arb_idx), N_REQ));
            r_bit_cnt <= '0;
            r_state   <= maze_pkg::LOAD;
          end else begin
            r_grant <= '0;
          end
        end

        // The winner's bit is sampled while its grant is high, so the solver
        // stream trails grant by exactly one cycle.
        maze_pkg::LOAD: begin
          r_ms_maze     <= req_bit[r_win];
          r_ms_in_valid <= 1'b1;
          if (r_bit_cnt == BCW'(MAZE_BITS - 1)) begin
            r_grant <= '0;
            r_timer <= '0;
            r_state <= maze_pkg::WAIT;
          end else begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
        end

        // A result arriving on the timeout cycle takes priority over the abort.
        maze_pkg::WAIT: begin
          r_ms_in_valid <= 1'b0;
          if (ms_out_valid) begin
            r_rsp_valid     <= w_win_oh;
            r_rsp_not_valid <= ms_maze_not_valid;
            r_rsp_x         <= ms_out_x;
            r_rsp_y         <= ms_out_y;
            r_state         <= maze_pkg::DRAIN;
          end else if (r_timer == TW'(TIMEOUT)) begin
            r_timeout_err   <= 1'b1;
            r_rsp_valid     <= w_win_oh;
            r_rsp_not_valid <= 1'b1;
            r_gap_cnt       <= '0;
            r_state         <= maze_pkg::GAP;
          end else if (r_timer != {TW{1'b1}}) begin
            r_timer <= r_timer + TW'(1);
          end else begin
            r_timer <= r_timer;
          end
        end

        // Entered only after ms_out_valid was high, so a low now is the falling edge.
        maze_pkg::DRAIN: begin
          if (ms_out_valid) begin
            r_rsp_valid     <= w_win_oh;
            r_rsp_not_valid <= ms_maze_not_valid;
            r_rsp_x         <= ms_out_x;
            r_rsp_y         <= ms_out_y;
          end else begin
            r_rsp_valid     <= '0;
            r_rsp_not_valid <= 1'b0;
            r_gap_cnt       <= '0;
            r_state         <= maze_pkg::GAP;
          end
        end

        maze_pkg::GAP: begin
          r_ms_in_valid   <= 1'b0;
          r_rsp_valid     <= '0;
          r_rsp_not_valid <= 1'b0;
          if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
            r_state <= maze_pkg::IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end

        default: begin
          r_grant         <= '0;
          r_ms_in_valid   <= 1'b0;
          r_rsp_valid     <= '0;
          r_rsp_not_valid <= 1'b0;
          r_state         <= maze_pkg::IDLE;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign ms_maze       = r_ms_maze;
  assign ms_in_valid   = r_ms_in_valid;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_not_valid = r_rsp_not_valid;
  assign rsp_x         = r_rsp_x;
  assign rsp_y         = r_rsp_y;
  assign timeout_err   = r_timeout_err;
  assign busy          = (r_state != maze_pkg::IDLE);

endmodule

// File: tb/tb_maze_job_sched.sv
// -----------------------------------------------------------------------------
// tb_maze_job_sched
//   Directed bench for maze_job_sched (N_REQ=2). The bench acts as both the
//   requesters and the solver; expected values are hand-derived timings.
// -----------------------------------------------------------------------------
module tb_maze_job_sched;
  import maze_pkg::*;

  localparam int N_REQ = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req_bit, grant, rsp_valid;
  logic       ms_maze, ms_in_valid, ms_out_valid, ms_maze_not_valid;
  logic       rsp_not_valid, busy, timeout_err;
  coord_t     ms_out_x, ms_out_y, rsp_x, rsp_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  maze_job_sched #(.N_REQ(2), .MAZE_BITS(225), .TIMEOUT(1023), .GAP_CYC(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .req_bit           (req_bit),
    .grant             (grant),
    .ms_maze           (ms_maze),
    .ms_in_valid       (ms_in_valid),
    .ms_out_valid      (ms_out_valid),
    .ms_maze_not_valid (ms_maze_not_valid),
    .ms_out_x          (ms_out_x),
    .ms_out_y          (ms_out_y),
    .rsp_valid         (rsp_valid),
    .rsp_not_valid     (rsp_not_valid),
    .rsp_x             (rsp_x),
    .rsp_y             (rsp_y),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic pat(input int k, input int seed);
    return (((k * 37 + seed) % 11) < 5);
  endfunction

  // Returns at the first falling edge with a grant; n counts grant-free edges.
  task automatic wait_grant(output int n);
    n = 0;
    while (grant === 2'b00 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("grant_seen", 32'(grant !== 2'b00), 32'd1);
  endtask

  // Called at LOAD cycle 0; returns at the second WAIT cycle.
  task automatic load_job(input int w, input int seed);
    int ng, niv, bad, first_iv;
    logic p;
    ng = 0; niv = 0; bad = 0; first_iv = -1;
    for (int c = 0; c <= 226; c++) begin
      if (c > 0) @(negedge clk);
      if (grant === oh(w)) ng++;
      else if (grant !== 2'b00) bad++;
      if (ms_in_valid === 1'b1) begin
        niv++;
        if (first_iv < 0) first_iv = c;
        if (ms_maze !== pat(c - 1, seed)) bad++;
      end
      p = pat(c, seed);
      req_bit = (w == 0) ? {~p, p} : {p, ~p};
    end
    chk("load_grant_cycles", 32'(ng), 32'd225);
    chk("load_in_valid_cycles", 32'(niv), 32'd225);
    chk("load_in_valid_lag", 32'(first_iv), 32'd1);
    chk("load_bits_and_onehot", 32'(bad), 32'd0);
    chk("load_busy_in_wait", 32'(busy), 32'd1);
  endtask

  // Solver model: drives npts points from the path table, then goes quiet.
  task automatic respond(input int w, input int npts, input logic nv);
    coord_t xs [0:4];
    coord_t ys [0:4];
    xs = '{4'd13, 4'd13, 4'd10, 4'd4, 4'd1};
    ys = '{4'd13, 4'd10, 4'd7,  4'd4, 4'd1};
    for (int i = 0; i < npts; i++) begin
      ms_out_valid      = 1'b1;
      ms_maze_not_valid = nv;
      ms_out_x          = xs[i];
      ms_out_y          = ys[i];
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'(oh(w)));
      chk("rsp_x", 32'(rsp_x), 32'(xs[i]));
      chk("rsp_y", 32'(rsp_y), 32'(ys[i]));
      chk("rsp_not_valid", 32'(rsp_not_valid), 32'(nv));
      chk("rsp_no_timeout", 32'(timeout_err), 32'd0);
    end
    ms_out_valid      = 1'b0;
    ms_maze_not_valid = 1'b0;
    ms_out_x          = 4'd15;
    ms_out_y          = 4'd15;
    @(negedge clk);
    chk("rsp_valid_end", 32'(rsp_valid), 32'd0);
    chk("rsp_not_valid_end", 32'(rsp_not_valid), 32'd0);
    chk("rsp_x_hold", 32'(rsp_x), 32'(xs[npts-1]));
    chk("busy_in_gap", 32'(busy), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int c;
    int order [0:3];
    order = '{0, 1, 0, 1};
    rst_n = 1'b0; req = 2'b00; req_bit = 2'b00;
    ms_out_valid = 1'b0; ms_maze_not_valid = 1'b0;
    ms_out_x = 4'd0; ms_out_y = 4'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_in_valid", 32'(ms_in_valid), 32'd0);
    chk("rst_ms_maze", 32'(ms_maze), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_not_valid", 32'(rsp_not_valid), 32'd0);
    chk("rst_rsp_xy", 32'({rsp_x, rsp_y}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1 + 3: single requester, full load, 5-point path
    req = 2'b01;
    wait_grant(n);
    chk("t1_grant", 32'(grant), 32'd1);
    req = 2'b00;
    load_job(0, 3);
    respond(0, 5, 1'b0);
    repeat (2) @(negedge clk);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2 + 4: both requesting, fresh pointer; job 1 gets a "no path" verdict
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_grant(n);
      chk("t2_rr_order", 32'(grant), 32'(oh(order[j])));
      if (j > 0) chk("t2_gap_len", 32'(n), 32'd3);
      if (j == 3) req = 2'b00;
      load_job(order[j], j + 5);
      if (j == 1) respond(order[j], 1, 1'b1);
      else        respond(order[j], j + 1, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_no_grant", 32'(grant), 32'd0);

    // 5: silent solver times out TIMEOUT+1 cycles after the last in_valid (c=225)
    req = 2'b01;
    wait_grant(n);
    chk("t5_grant", 32'(grant), 32'd1);
    req = 2'b00;
    load_job(0, 11);
    c = 226;
    while (timeout_err !== 1'b1 && c < 1400) begin
      @(negedge clk);
      c++;
    end
    chk("t5_timeout_cycle", 32'(c), 32'd1249);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t5_rsp_not_valid", 32'(rsp_not_valid), 32'd1);
    @(negedge clk);
    chk("t5_pulse_end", 32'({timeout_err, rsp_not_valid, rsp_valid}), 32'd0);
    chk("t5_gap_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t5_idle", 32'(busy), 32'd0);

    // 5b: response on the very cycle the timer hits TIMEOUT wins
    req = 2'b10;
    wait_grant(n);
    chk("t5b_grant", 32'(grant), 32'd2);
    req = 2'b00;
    load_job(1, 13);
    repeat (1248 - 226) @(negedge clk);
    chk("t5b_no_early_timeout", 32'(timeout_err), 32'd0);
    respond(1, 2, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5b_idle", 32'(busy), 32'd0);

    // 6: asynchronous reset at LOAD bit 100
    req = 2'b01;
    wait_grant(n);
    req = 2'b00;
    repeat (100) @(negedge clk);
    chk("t6_mid_load", 32'({grant, ms_in_valid}), 32'b011);
    rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_in_valid", 32'(ms_in_valid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b10;
    wait_grant(n);
    chk("t6_first_grant", 32'(grant), 32'd2);
    req = 2'b00;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
